// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiter.
package uart_pkg;

  localparam int UART_DBIT = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority.sv
// Rotate-and-find-first picker: returns the first set request at or after start_i, wrapping.
module rr_priority #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX FIFO write port among N_REQ requesters.
// The owner keeps the port until it delivers a byte marked last or the idle watchdog fires.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DBIT    = UART_DBIT,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      grant,
  output logic                  wr_uart,
  output logic [DBIT-1:0]       w_data,
  input  logic                  tx_full,
  output logic                  busy,
  output logic                  abort,
  output logic                  state_dbg
);

  localparam int          IW       = $clog2(N_REQ);
  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          WD_EN    = (TIMEOUT > 0);
  localparam int unsigned TMAX     = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = TMAX[CW-1:0];
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  arb_state_t       state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_owner_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             abort_q;
  logic [CW-1:0]    cnt_q;

  logic             locked;
  logic             owner_valid;
  logic             owner_last;
  logic [DBIT-1:0]  owner_data;
  logic             xfer;
  logic [IW-1:0]    start_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;

  assign locked      = (state_q == ARB_LOCKED);
  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = req_data[owner_q*DBIT +: DBIT];
  assign xfer        = locked && owner_valid && !tx_full;
  assign start_idx   = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + 1'b1;

  rr_priority #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .start_i (start_idx),
    .pick_o  (pick_oh),
    .idx_o   (pick_idx)
  );

  // Ready and the write strobe follow tx_full combinationally so a full FIFO is never written.
  assign req_ready = (locked && !tx_full) ? grant_q : '0;
  assign wr_uart   = xfer;
  assign w_data    = xfer ? owner_data : '0;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign abort     = abort_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (|req_valid) begin
            state_q <= ARB_LOCKED;
            owner_q <= pick_idx;
            grant_q <= pick_oh;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            cnt_q <= '0;
            if (owner_last) begin
              state_q      <= ARB_IDLE;
              last_owner_q <= owner_q;
              grant_q      <= '0;
              busy_q       <= 1'b0;
            end
          end else if (!owner_valid && WD_EN) begin
            // Firing on the increment that would reach TIMEOUT lands abort in the first idle cycle.
            if (cnt_q == CNT_MAX) begin
              state_q      <= ARB_IDLE;
              last_owner_q <= owner_q;
              grant_q      <= '0;
              busy_q       <= 1'b0;
              abort_q      <= 1'b1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a cycle-level behavioural model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            wr_uart;
  logic [DW-1:0]   w_data;
  logic            tx_full;
  logic            busy;
  logic            abort;
  logic            state_dbg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DBIT(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .wr_uart(wr_uart),
    .w_data(w_data), .tx_full(tx_full), .busy(busy), .abort(abort), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: each queue entry is {last, data}.
  logic [8:0] pq[N][$];
  int hold[N];
  int gap_fixed[N];
  int gap_rand_max;
  bit full_rand;
  int full_pct;

  // Behavioural model of the port owner.
  bit m_locked;
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_abort;
  int cyc;
  int abort_gap;
  int last_xfer_cyc;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  function automatic bit pending();
    bit p = m_locked;
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic int next_gap(input int i);
    return gap_fixed[i] + ((gap_rand_max > 0) ? int'($urandom_range(0, gap_rand_max)) : 0);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i]         = (hold[i] == 0);
        req_data[i*DW +: DW] = pq[i][0][7:0];
        req_last[i]          = pq[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i]          = 1'($urandom);
      end
    end
    if (full_rand) tx_full = ($urandom_range(0, 99) < full_pct);
  endtask

  // Entered and left at posedge+1: drive, check at the falling edge, advance the model on the rising edge.
  task automatic cycle();
    logic [N-1:0] eg, er;
    logic         xfer, lastf, any;
    logic [7:0]   ed;
    int           pick;
    bit           new_abort;
    drive();
    #4;
    eg = '0;
    if (m_locked) eg[m_owner] = 1'b1;
    xfer = m_locked && req_valid[m_owner] && !tx_full;
    er   = (m_locked && !tx_full) ? eg : '0;
    ed   = xfer ? pq[m_owner][0][7:0] : 8'h00;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_locked));
    check("abort", 32'(abort), 32'(m_abort));
    check("req_ready", 32'(req_ready), 32'(er));
    check("wr_uart", 32'(wr_uart), 32'(xfer));
    check("w_data", 32'(w_data), 32'(ed));
    if (wr_uart === 1'b1) got_q.push_back(w_data);
    @(posedge clk);
    new_abort = 1'b0;
    for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    if (!m_locked) begin
      any  = |req_valid;
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
      if (any) begin
        m_locked = 1'b1;
        m_owner  = pick;
        m_cnt    = 0;
      end
    end else if (xfer) begin
      lastf = pq[m_owner][0][8];
      void'(pq[m_owner].pop_front());
      hold[m_owner] = next_gap(m_owner);
      m_cnt = 0;
      last_xfer_cyc = cyc;
      if (lastf) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end else if (!req_valid[m_owner]) begin
      m_cnt++;
      if (m_cnt == TO) begin
        m_locked  = 1'b0;
        m_last    = m_owner;
        new_abort = 1'b1;
        m_cnt     = 0;
        abort_gap = (cyc + 1) - last_xfer_cyc;
      end
    end
    m_abort = new_abort;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);
    check("rst_wr_uart", 32'(wr_uart), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_w_data", 32'(w_data), 32'h0);
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      hold[i]      = 0;
      gap_fixed[i] = 0;
    end
    gap_rand_max = 0;
    full_rand    = 1'b0;
    tx_full      = 1'b0;
    req_valid    = '0;
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
    m_cnt    = 0;
    m_abort  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 32'(pending()), 32'h0);
    cycle();
    cycle();
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic push_pkt(input int r, input logic [7:0] first, input int len);
    for (int b = 0; b < len; b++) pq[r].push_back({(b == len - 1), first + 8'(b)});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    cyc       = 0;
    #1;

    // Two simultaneous 3-byte packets are sent whole, requester 0 first.
    do_reset();
    push_pkt(0, 8'h41, 3);
    push_pkt(2, 8'h61, 3);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
    drain("two_pkt", 100);
    compare_bytes("two_pkt");

    // Four continuous single-byte requesters rotate fairly.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_pkt(i, 8'h10 + 8'(i), 1);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
    drain("rotate", 100);
    compare_bytes("rotate");

    // FIFO full for five cycles mid-packet.
    do_reset();
    push_pkt(1, 8'hA0, 6);
    push_pkt(3, 8'hB0, 1);
    for (int k = 0; k < 3; k++) cycle();
    tx_full = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    tx_full = 1'b0;
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hB0};
    drain("full", 100);
    compare_bytes("full");

    // Owner stalls after a non-last byte; watchdog releases it.
    do_reset();
    pq[1].push_back({1'b0, 8'h55});
    pq[2].push_back({1'b1, 8'h77});
    abort_gap = -1;
    exp_q = '{8'h55, 8'h77};
    drain("timeout", 100);
    compare_bytes("timeout");
    check("abort_gap", 32'(abort_gap), 32'd9);

    // Owner gaps of three cycles; waiting requester is not interleaved.
    do_reset();
    gap_fixed[0] = 3;
    push_pkt(0, 8'hC0, 4);
    push_pkt(1, 8'hD0, 2);
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
    drain("gaps", 200);
    compare_bytes("gaps");

    // Reset in the middle of a packet, then requester 0 wins over 3.
    do_reset();
    push_pkt(2, 8'hE0, 6);
    for (int k = 0; k < 3; k++) cycle();
    exp_q = '{8'hE0, 8'hE1};
    compare_bytes("pre_rst");
    do_reset();
    push_pkt(3, 8'h33, 1);
    push_pkt(0, 8'h30, 1);
    exp_q = '{8'h30, 8'h33};
    drain("post_rst", 100);
    compare_bytes("post_rst");

    // Randomised traffic, gaps and back-pressure.
    for (int r = 0; r < 30; r++) begin
      int np;
      np = $urandom_range(1, 6);
      for (int p = 0; p < np; p++)
        push_pkt($urandom_range(0, N - 1), 8'($urandom), $urandom_range(1, 5));
      gap_rand_max = (r % 5 == 4) ? 12 : $urandom_range(0, 2);
      full_pct     = $urandom_range(0, 40);
      full_rand    = 1'b1;
      drain("random", 3000);
      full_rand    = 1'b0;
      tx_full      = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
